dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Data-memory port arbiter and stall controller for the single-cycle core. It shares the one data-memory port between the datapath's load/store path and the debug/loader port, and hides a fixed-latency memory behind a stall signal. It sits between the datapath's data-memory address/data outputs and the data RAM. `cpu_stall` freezes PC update and register write-back while a CPU access is outstanding.

## Interface
- `WAIT_CYCLES`, default 1: cycles `mem_en` is held per access. Legal range 1..15.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `cpu_req` in 1: datapath load/store request. Held with its fields until the cycle `cpu_stall` is low.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address (the ALU result).
- `cpu_wdata` in 32: store data (rs2).
- `cpu_rdata` out 32: load data. Registered.
- `cpu_stall` out 1: combinational. High while `cpu_req` is high and its access is not in RESP.
- `dbg_req` in 1: debug request. Held until `dbg_ack`.
- `dbg_we` in 1: debug write enable.
- `dbg_addr` in 32: debug address.
- `dbg_wdata` in 32: debug write data.
- `dbg_rdata` out 32: debug read data. Registered.
- `dbg_ack` out 1: one-cycle completion pulse.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data. Valid in the last `mem_en` cycle of a read.

## Operation
- **States:** IDLE, BUSY, RESP.
- **Registers:** `owner` (CPU/DBG), `last_grant`, 4-bit `wait_cnt`, latched `we`/`addr`/`wdata`, `cpu_rdata`, `dbg_rdata`.
- **IDLE:**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the port not equal to `last_grant` (round-robin).
  - On grant: latch the winner's we/addr/wdata, set `owner` and `last_grant` to the winner, set `wait_cnt` = `WAIT_CYCLES`-1, go to BUSY.
- **BUSY:**
  - `mem_en`=1 and `mem_we`/`mem_addr`/`mem_wdata` come from the latched fields, stable for the whole state.
  - If `wait_cnt`≠0: decrement and stay.
  - If `wait_cnt`=0 and the access is a read: capture `mem_rdata` into the owner's rdata register at this edge. Then go to RESP.
  - Writes leave both rdata registers unchanged.
- **RESP:**
  - `mem_en`=0.
  - If `owner`=CPU: `cpu_stall`=0 even though `cpu_req` is high.
  - If `owner`=DBG: `dbg_ack`=1.
  - Always go to IDLE. No grant is made in RESP, because the requester's `req` in that cycle still belongs to the finished access.
- **`cpu_stall` equation:** `cpu_req & !(state==RESP & owner==CPU)`. A losing or waiting CPU request stalls.
- **Request withdrawn mid-access:** protocol violation. The access still completes from the latched fields; the ack or un-stall is still produced.
- **Outputs outside BUSY:** `mem_en`=`mem_we`=0; `mem_addr` and `mem_wdata` hold the latched values.

## Timing
- **Reset values** (at the edge with `rst`=1, regardless of state):
  - state IDLE; `last_grant`=DBG, so the CPU wins the first tie.
  - `wait_cnt`=0; latched fields 0; `cpu_rdata`=`dbg_rdata`=0.
  - An in-flight access is abandoned with no ack.
- **Outputs while `rst` is high:** `cpu_stall`=0, `dbg_ack`=0, `mem_en`=0.
- **Latency, request seen in IDLE at cycle T:**
  - `mem_en` high in cycles T+1..T+W, where W=`WAIT_CYCLES`.
  - RESP in cycle T+W+1: CPU un-stalled and `cpu_rdata` valid, or `dbg_ack`=1.
  - IDLE in cycle T+W+2.
  - A CPU access stalls for W+1 cycles (T..T+W).
- **Loser of a tie:** granted at the IDLE following the winner's RESP. Worst-case wait is 2W+3 cycles to its own RESP.
- **Back-to-back requests:** a same-port request arriving in the cycle after RESP gets a grant at that IDLE cycle. Minimum issue spacing is W+2 cycles.
- **`dbg_ack`:** exactly one cycle per granted debug access.
- **`cpu_rdata`/`dbg_rdata`:** hold their value until the next completed read by the same port.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `cpu_req`=1.
  - During reset: `cpu_stall`=0, `mem_en`=0, `cpu_rdata`=0.
  - First cycle after release: `cpu_stall`=1.
- **CPU load, W=1:** memory returns 0xDEADBEEF for address 0x10; `cpu_req`=1, `cpu_we`=0, addr 0x10 at cycle T.
  - `mem_en`=1 at T+1 only.
  - `cpu_stall`=1 at T and T+1, 0 at T+2.
  - `cpu_rdata`=0xDEADBEEF at T+2.
- **CPU store, W=3:** store 0x12345678 to 0x20.
  - `mem_en`/`mem_we`=1 for exactly 3 cycles with stable addr/data.
  - `cpu_rdata` unchanged; 4 stall cycles.
- **Simultaneous requests from reset:** `cpu_req` and `dbg_req` both high at cycle T.
  - CPU granted first; `dbg` granted at the IDLE after CPU's RESP.
  - On the next tie, DBG wins.
- **Debug read, W=2:** memory returns 0xA5A5A5A5 for address 0x40.
  - `dbg_ack` is a single pulse at T+3 with `dbg_rdata`=0xA5A5A5A5.
  - `cpu_rdata` unchanged.
- **Reset mid-access:** W=4; assert `rst` at the 2nd BUSY cycle of a debug write.
  - No `dbg_ack`.
  - `mem_en`=0 from the next cycle.
  - State IDLE; a re-issued request starts fresh.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and the debug port,
// holding mem_en for WAIT_CYCLES per access and stalling the CPU until its response cycle.
module dmem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic {OwnCpu, OwnDbg} owner_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_grant_q, last_grant_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        grant_cpu, grant_dbg;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    grant_cpu    = 1'b0;
    grant_dbg    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the port that did not win last time goes first.
        grant_cpu = cpu_req && (!dbg_req || last_grant_q == OwnDbg);
        grant_dbg = dbg_req && !grant_cpu;
        if (grant_cpu) begin
          owner_d      = OwnCpu;
          last_grant_d = OwnCpu;
          we_d         = cpu_we;
          addr_d       = cpu_addr;
          wdata_d      = cpu_wdata;
          wait_cnt_d   = WaitInit;
          state_d      = StBusy;
        end else if (grant_dbg) begin
          owner_d      = OwnDbg;
          last_grant_d = OwnDbg;
          we_d         = dbg_we;
          addr_d       = dbg_addr;
          wdata_d      = dbg_wdata;
          wait_cnt_d   = WaitInit;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            if (owner_q == OwnCpu) begin
              cpu_rdata_d = mem_rdata;
            end else begin
              dbg_rdata_d = mem_rdata;
            end
          end
          state_d = StResp;
        end
      end
      StResp: begin
        // The requester's req is still high here for the access just finished.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      last_grant_q <= OwnDbg;
      wait_cnt_q   <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      cpu_rdata_q  <= 32'd0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    mem_en    = !rst && (state_q == StBusy);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_stall = !rst && cpu_req && !(state_q == StResp && owner_q == OwnCpu);
    dbg_ack   = !rst && (state_q == StResp) && (owner_q == OwnDbg);
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: four instances with WAIT_CYCLES 1..4 share one stimulus stream;
// each scenario watches the instance whose latency it targets.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;

  logic        cpu_stall[4];
  logic        dbg_ack[4];
  logic        mem_en[4];
  logic        mem_we[4];
  logic [31:0] cpu_rdata[4];
  logic [31:0] dbg_rdata[4];
  logic [31:0] mem_addr[4];
  logic [31:0] mem_wdata[4];
  logic [31:0] mem_rdata[4];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cpu_exp_q[$];
  logic [31:0] dbg_exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h40:  return 32'hA5A5A5A5;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_arbiter #(.WAIT_CYCLES(g + 1)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[g]),
      .cpu_stall(cpu_stall[g]),
      .dbg_req  (dbg_req),
      .dbg_we   (dbg_we),
      .dbg_addr (dbg_addr),
      .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata[g]),
      .dbg_ack  (dbg_ack[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = mem_model(mem_addr[g]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (cpu_stall[0] !== 1'b0) begin
        n_err++; $display("FAIL reset_stall: got %b want 0", cpu_stall[0]);
      end
      n_cmp++;
      if (mem_en[0] !== 1'b0) begin
        n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en[0]);
      end
      n_cmp++;
      if (cpu_rdata[0] !== 32'd0) begin
        n_err++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata[0]);
      end
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cpu_stall[0] !== 1'b1) begin
      n_err++; $display("FAIL post_reset_stall: got %b want 1", cpu_stall[0]);
    end
    cyc();
    cpu_req = 1'b0;
  endtask

  // W=1 load from 0x10.
  task automatic test_cpu_load();
    do_reset(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    cpu_exp_q.push_back(32'hDEADBEEF);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_en[0] !== (k == 1)) begin
        n_err++; $display("FAIL load_mem_en k=%0d: got %b want %b", k, mem_en[0], (k == 1));
      end
      n_cmp++;
      if (cpu_stall[0] !== (k <= 1)) begin
        n_err++; $display("FAIL load_stall k=%0d: got %b want %b", k, cpu_stall[0], (k <= 1));
      end
      if (k == 2) begin
        exp = cpu_exp_q.pop_front();
        n_cmp++;
        if (cpu_rdata[0] !== exp) begin
          n_err++; $display("FAIL load_rdata: got %h want %h", cpu_rdata[0], exp);
        end
      end
      cyc();
      if (k == 2) cpu_req = 1'b0;
    end
  endtask

  // W=3: a load to seed cpu_rdata, then a back-to-back store.
  task automatic test_cpu_store();
    bit done;
    int stalls;
    do_reset(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    cpu_exp_q.push_back(32'hDEADBEEF);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!cpu_stall[2]) begin
        done = 1'b1;
        exp = cpu_exp_q.pop_front();
        n_cmp++;
        if (cpu_rdata[2] !== exp) begin
          n_err++; $display("FAIL seed_load_rdata: got %h want %h", cpu_rdata[2], exp);
        end
      end
      cyc();
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL seed_load_timeout: got no unstall want unstall within 20 cycles");
    end
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    cpu_exp_q.push_back(32'hDEADBEEF);
    stalls = 0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (cpu_stall[2]) stalls++;
      n_cmp++;
      if (mem_en[2] !== (k >= 1 && k <= 3)) begin
        n_err++; $display("FAIL store_mem_en k=%0d: got %b", k, mem_en[2]);
      end
      n_cmp++;
      if (mem_we[2] !== (k >= 1 && k <= 3)) begin
        n_err++; $display("FAIL store_mem_we k=%0d: got %b", k, mem_we[2]);
      end
      if (k >= 1 && k <= 3) begin
        n_cmp++;
        if (mem_addr[2] !== 32'h20 || mem_wdata[2] !== 32'h12345678) begin
          n_err++;
          $display("FAIL store_fields k=%0d: got %h/%h want 00000020/12345678",
                   k, mem_addr[2], mem_wdata[2]);
        end
      end
      if (k == 4) begin
        exp = cpu_exp_q.pop_front();
        n_cmp++;
        if (cpu_rdata[2] !== exp) begin
          n_err++; $display("FAIL store_rdata_kept: got %h want %h", cpu_rdata[2], exp);
        end
      end
      cyc();
      if (k == 4) cpu_req = 1'b0;
    end
    n_cmp++;
    if (stalls != 4) begin
      n_err++; $display("FAIL store_stall_cycles: got %0d want 4", stalls);
    end
  endtask

  // W=1: CPU wins the tie out of reset; after a solo CPU access DBG wins the next tie.
  task automatic test_tie();
    bit done;
    int cpu_done, dbg_done, acks;
    logic [31:0] first_addr;
    do_reset(2);
    for (int round = 0; round < 2; round++) begin
      if (round == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h84;
        cpu_exp_q.push_back(mem_model(32'h84));
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
          @(negedge clk);
          if (!cpu_stall[0]) begin
            done = 1'b1;
            exp = cpu_exp_q.pop_front();
            n_cmp++;
            if (cpu_rdata[0] !== exp) begin
              n_err++; $display("FAIL solo_rdata: got %h want %h", cpu_rdata[0], exp);
            end
          end
          cyc();
        end
        if (!done) begin
          n_cmp++; n_err++;
          $display("FAIL solo_timeout: got no unstall want unstall within 20 cycles");
        end
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = (round == 0) ? 32'h80 : 32'h88;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = (round == 0) ? 32'h90 : 32'h94;
      first_addr = (round == 0) ? cpu_addr : dbg_addr;
      cpu_exp_q.push_back(mem_model(cpu_addr));
      dbg_exp_q.push_back(mem_model(dbg_addr));
      cpu_done = -1; dbg_done = -1; acks = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (k == 1) begin
          n_cmp++;
          if (mem_en[0] !== 1'b1 || mem_addr[0] !== first_addr) begin
            n_err++;
            $display("FAIL tie%0d_first_grant: got en=%b addr=%h want en=1 addr=%h",
                     round, mem_en[0], mem_addr[0], first_addr);
          end
        end
        if (cpu_req && !cpu_stall[0] && cpu_done < 0) begin
          cpu_done = k;
          exp = cpu_exp_q.pop_front();
          n_cmp++;
          if (cpu_rdata[0] !== exp) begin
            n_err++; $display("FAIL tie%0d_cpu_rdata: got %h want %h", round, cpu_rdata[0], exp);
          end
        end
        if (dbg_ack[0]) begin
          acks++;
          if (dbg_done < 0) begin
            dbg_done = k;
            exp = dbg_exp_q.pop_front();
            n_cmp++;
            if (dbg_rdata[0] !== exp) begin
              n_err++;
              $display("FAIL tie%0d_dbg_rdata: got %h want %h", round, dbg_rdata[0], exp);
            end
          end
        end
        cyc();
        if (cpu_done >= 0) cpu_req = 1'b0;
        if (dbg_done >= 0) dbg_req = 1'b0;
      end
      n_cmp++;
      if (cpu_done != ((round == 0) ? 2 : 5)) begin
        n_err++; $display("FAIL tie%0d_cpu_resp_cycle: got %0d want %0d", round, cpu_done,
                          (round == 0) ? 2 : 5);
      end
      n_cmp++;
      if (dbg_done != ((round == 0) ? 5 : 2)) begin
        n_err++; $display("FAIL tie%0d_dbg_ack_cycle: got %0d want %0d", round, dbg_done,
                          (round == 0) ? 5 : 2);
      end
      n_cmp++;
      if (acks != 1) begin
        n_err++; $display("FAIL tie%0d_ack_count: got %0d want 1", round, acks);
      end
      cpu_req = 1'b0; dbg_req = 1'b0;
    end
  endtask

  // W=2: debug read after a CPU load; CPU read data must survive.
  task automatic test_dbg_read();
    bit done;
    do_reset(2);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    cpu_exp_q.push_back(32'hDEADBEEF);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (!cpu_stall[1]) begin
        done = 1'b1;
        exp = cpu_exp_q.pop_front();
        n_cmp++;
        if (cpu_rdata[1] !== exp) begin
          n_err++; $display("FAIL dbg_seed_rdata: got %h want %h", cpu_rdata[1], exp);
        end
      end
      cyc();
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL dbg_seed_timeout: got no unstall want unstall within 20 cycles");
    end
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    dbg_exp_q.push_back(32'hA5A5A5A5);
    cpu_exp_q.push_back(32'hDEADBEEF);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dbg_ack[1] !== (k == 3)) begin
        n_err++; $display("FAIL dbg_ack k=%0d: got %b want %b", k, dbg_ack[1], (k == 3));
      end
      if (k == 3) begin
        exp = dbg_exp_q.pop_front();
        n_cmp++;
        if (dbg_rdata[1] !== exp) begin
          n_err++; $display("FAIL dbg_rdata: got %h want %h", dbg_rdata[1], exp);
        end
      end
      if (k == 4) begin
        exp = cpu_exp_q.pop_front();
        n_cmp++;
        if (cpu_rdata[1] !== exp) begin
          n_err++; $display("FAIL dbg_cpu_rdata_kept: got %h want %h", cpu_rdata[1], exp);
        end
      end
      cyc();
      if (k == 3) dbg_req = 1'b0;
    end
  endtask

  // W=4: reset lands in the 2nd BUSY cycle of a debug write, then a fresh debug read.
  task automatic test_reset_mid();
    int acks;
    do_reset(2);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h50; dbg_wdata = 32'hCAFEF00D;
    acks = 0;
    for (int k = 0; k <= 5; k++) begin
      if (k == 2) rst = 1'b1;
      if (k == 3) begin
        rst = 1'b0; dbg_req = 1'b0;
      end
      @(negedge clk);
      if (dbg_ack[3]) acks++;
      if (k == 1) begin
        n_cmp++;
        if (mem_en[3] !== 1'b1 || mem_we[3] !== 1'b1) begin
          n_err++; $display("FAIL mid_busy: got en=%b we=%b want 1/1", mem_en[3], mem_we[3]);
        end
      end
      if (k >= 2) begin
        n_cmp++;
        if (mem_en[3] !== 1'b0) begin
          n_err++; $display("FAIL mid_mem_en k=%0d: got %b want 0", k, mem_en[3]);
        end
      end
      cyc();
    end
    n_cmp++;
    if (acks != 0) begin
      n_err++; $display("FAIL mid_abandoned_ack: got %0d want 0", acks);
    end
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    dbg_exp_q.push_back(32'hA5A5A5A5);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_en[3] !== (k >= 1 && k <= 4)) begin
        n_err++; $display("FAIL fresh_mem_en k=%0d: got %b", k, mem_en[3]);
      end
      n_cmp++;
      if (dbg_ack[3] !== (k == 5)) begin
        n_err++; $display("FAIL fresh_ack k=%0d: got %b want %b", k, dbg_ack[3], (k == 5));
      end
      if (k == 5) begin
        exp = dbg_exp_q.pop_front();
        n_cmp++;
        if (dbg_rdata[3] !== exp) begin
          n_err++; $display("FAIL fresh_rdata: got %h want %h", dbg_rdata[3], exp);
        end
      end
      cyc();
      if (k == 5) dbg_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_cpu_load();
    test_cpu_store();
    test_tie();
    test_dbg_read();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
